rv_pipe_buffer: RTL and testbench
=================================

# rv_pipe_buffer

Parametrised elastic pipeline buffer that replaces the fixed `register_w_enable` stage latches and hand-built stall/flush muxing between pipeline stages. Each instance is a `DEPTH`-entry FIFO carrying a `WIDTH`-bit payload, with valid/ready handshakes on both sides and a synchronous flush. Stall becomes back-pressure (`out_ready` low) and bubble insertion becomes a flush. It sits between any two stages of the RV32I pipeline, such as IF/ID or ID/EXE.

## Interface
- `WIDTH`, default 32: payload width in bits, ≥1.
- `DEPTH`, default 2: number of storage entries, ≥1.
- `CW`, default `$clog2(DEPTH+1)`: occupancy counter width; derived, never overridden.
- `clk` input, 1: single clock; all state is updated on its rising edge.
- `rst_n` input, 1: asynchronous reset, active-low.
- `flush` input, 1: synchronous discard of all entries.
- `in_valid` input, 1: upstream presents `in_data`.
- `in_ready` output, 1: buffer accepts this cycle.
- `in_data` input, WIDTH: upstream payload.
- `out_valid` output, 1: head entry valid.
- `out_ready` input, 1: downstream consumes the head entry this cycle.
- `out_data` output, WIDTH: head payload.
- `count` output, CW: current occupancy, 0..DEPTH.

## Operation
- Storage: circular array of `DEPTH` entries, with write pointer `wp` and read pointer `rp`, each `$clog2(DEPTH)` bits (1 bit minimum). Occupancy is held in `count`.
- Push: `in_valid && in_ready`. Writes `in_data` at `wp`, then advances `wp`.
- Pop: `out_valid && out_ready`. Advances `rp`.
- Pointer wrap: a pointer equal to `DEPTH-1` advances to 0. `DEPTH` need not be a power of two.
- `in_ready = (count != DEPTH)`, registered-derived. There is no combinational path from `out_ready` to `in_ready`. When full, a push is refused even if a pop occurs in the same cycle.
- `out_valid = (count != 0)`. `out_data = mem[rp]`, a mux output of registered storage.
- Simultaneous push and pop with 0 < `count` < `DEPTH`: `count` is unchanged and both pointers advance.
- `flush` has priority over everything. In the flush cycle a push and a pop may still appear to handshake, but both are discarded. On the next edge, `count`, `wp` and `rp` are set to 0. Storage contents are not cleared.
- `in_valid` low with `in_data` X must not corrupt state.
- `out_data` is held stable while `out_valid && !out_ready`.
- Upstream must hold `in_data` stable while `in_valid && !in_ready`. The buffer does not check this.

## Timing
- Reset (`rst_n` low, asynchronous): `count`=0, `wp`=`rp`=0, all storage entries = 0. As a result `out_valid`=0, `in_ready`=1 and `out_data`=0.
- Reset is honoured mid-operation on any cycle. Buffered entries are lost.
- Latency without bypass: data pushed at edge N is visible on `out_data` with `out_valid`=1 after edge N. It can be consumed at edge N+1.
- Throughput: one item per cycle when `DEPTH` ≥ 2 and downstream is always ready.
- Throughput with `DEPTH`=1: one item every 2 cycles, because a full buffer refuses a concurrent push.
- After `flush` at edge N: `out_valid`=0 and `in_ready`=1 from edge N onward.
- Empty boundary: a pop cannot occur because `out_valid`=0.
- Full boundary: a push cannot occur because `in_ready`=0.
- `count` never leaves the range 0..`DEPTH`.

## Configuration
- `RV_PIPEBUF_BYPASS_EN` defined: zero-latency bypass is compiled in.
  - When `count`==0 and `in_valid`=1: `out_valid`=1 and `out_data`=`in_data` combinationally.
  - If `out_ready`=1 in that cycle, the item passes through and is not stored; `count` stays 0.
  - Otherwise the item is stored normally.
  - During `flush`, bypass is suppressed: `out_valid`=0.
- `RV_PIPEBUF_BYPASS_EN` not defined: no combinational path exists from `in_*` to `out_*`, and latency is as stated in Timing.

## Test plan
- Reset/idle: assert `rst_n`=0 mid-stream with `count`=2, then release → `out_valid`=0, `in_ready`=1, `count`=0, `out_data`=0.
- Streaming, `DEPTH`=2, `out_ready`=1: push 0x1..0x8 on consecutive cycles → pops 0x1..0x8 in order, each 1 cycle after its push (0 cycles with bypass), and `count` ≤1 throughout.
- Back-pressure/full, `DEPTH`=3, `out_ready`=0: push 0xA, 0xB, 0xC, 0xD → `in_ready` drops after 0xC and 0xD is held. Raise `out_ready` → outputs 0xA, 0xB, 0xC, 0xD with no loss or duplication; `in_ready` returns the cycle after the first pop.
- Wrap-around, `DEPTH`=3 (non-power-of-two): 10 interleaved push/pop sequences with random `out_ready` → scoreboard matches, and pointers wrap 2→0.
- Flush: fill to `count`=2, then assert `flush` together with `in_valid` carrying 0x55 → next cycle `count`=0 and `out_valid`=0; 0x55 never appears at the output.
- `DEPTH`=1, `WIDTH`=96: continuous `in_valid` with `out_ready`=1 → one accepted item every 2 cycles, with all 96 bits intact.

Source files
------------

// File: rtl/rv_pipe_buffer.sv
// Elastic valid/ready pipeline buffer: DEPTH-entry circular FIFO with synchronous flush.
// Define RV_PIPEBUF_BYPASS_EN to compile in the zero-latency empty-buffer bypass.
module rv_pipe_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop, store, retire;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    in_ready = (count_q != FULL);
    push     = in_valid && in_ready;
`ifdef RV_PIPEBUF_BYPASS_EN
    out_valid = !flush && ((count_q != '0) || in_valid);
    out_data  = (count_q == '0) ? in_data : mem_q[rp_q];
    // An item consumed while the buffer is empty passes straight through.
    store     = push && !((count_q == '0) && out_ready);
`else
    out_valid = (count_q != '0);
    out_data  = mem_q[rp_q];
    store     = push;
`endif
    pop    = out_valid && out_ready;
    retire = pop && (count_q != '0);
  end

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (store)  wp_d = ptr_inc(wp_q);
      if (retire) rp_d = ptr_inc(rp_q);
      case ({store, retire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (store && !flush) begin
      mem_q[wp_q] <= in_data;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_rv_pipe_buffer.sv
// Randomized and directed bench for rv_pipe_buffer: three instances (DEPTH 2/3/1) share one
// stimulus stream and are each compared every cycle against a queue-based reference model.
module tb_rv_pipe_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [95:0] in_data = '0;

  logic        ir0, ov0, ir1, ov1, ir2, ov2;
  logic [31:0] od0, od1;
  logic [95:0] od2;
  logic [1:0]  count0, count1;
  logic [0:0]  count2;

  rv_pipe_buffer #(.WIDTH(32), .DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data[31:0]), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .count(count0));

  rv_pipe_buffer #(.WIDTH(32), .DEPTH(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data[31:0]), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .count(count1));

  rv_pipe_buffer #(.WIDTH(96), .DEPTH(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir2),
    .in_data(in_data), .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
    .count(count2));

  always #5 clk = ~clk;

  logic [95:0] od [3];
  logic        ov [3];
  logic        ir [3];
  int          cnt [3];

  always_comb begin
    od[0] = {64'b0, od0};  od[1] = {64'b0, od1};  od[2] = od2;
    ov[0] = ov0;           ov[1] = ov1;           ov[2] = ov2;
    ir[0] = ir0;           ir[1] = ir1;           ir[2] = ir2;
    cnt[0] = int'(count0); cnt[1] = int'(count1); cnt[2] = int'(count2);
  end

  int          dep [3] = '{2, 3, 1};
  logic [95:0] msk [3] = '{96'hFFFF_FFFF, 96'hFFFF_FFFF, {96{1'b1}}};
  logic [95:0] mq [3][$];

  int n_chk = 0;
  int n_pass = 0;
  int hs_d1 = 0;
  bit last_acc_d1 = 1'b0;

  task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // One clock: compare outputs at the falling edge, then advance the model at the rising edge.
  task automatic cyc();
    bit          pe [3];
    bit          ue [3];
    int          sz [3];
    logic        exp_ov;
    logic [95:0] exp_od;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sz[i]  = mq[i].size();
      exp_ov = (sz[i] != 0);
      exp_od = (sz[i] != 0) ? mq[i][0] : '0;
`ifdef RV_PIPEBUF_BYPASS_EN
      if (sz[i] == 0) begin
        exp_ov = in_valid;
        exp_od = in_data & msk[i];
      end
      if (flush) exp_ov = 1'b0;
`endif
      chk($sformatf("d%0d_count", dep[i]), 96'(cnt[i]), 96'(sz[i]));
      chk($sformatf("d%0d_in_ready", dep[i]), 96'(ir[i]), 96'(sz[i] != dep[i]));
      chk($sformatf("d%0d_out_valid", dep[i]), 96'(ov[i]), 96'(exp_ov));
      if (exp_ov) chk($sformatf("d%0d_out_data", dep[i]), od[i], exp_od);
      pe[i] = exp_ov && out_ready;
      ue[i] = in_valid && (sz[i] != dep[i]);
    end
    last_acc_d1 = in_valid && ir[2];
    if (last_acc_d1) hs_d1++;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (flush) mq[i].delete();
      else if (pe[i] && sz[i] == 0) begin
        // pass-through item is never stored
      end else begin
        if (pe[i]) void'(mq[i].pop_front());
        if (ue[i]) mq[i].push_back(in_data & msk[i]);
      end
    end
    #1;
  endtask

  task automatic rst_chk(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_d%0d_count", tag, dep[i]), 96'(cnt[i]), 96'(0));
      chk($sformatf("%s_d%0d_in_ready", tag, dep[i]), 96'(ir[i]), 96'(1));
      chk($sformatf("%s_d%0d_out_valid", tag, dep[i]), 96'(ov[i]), 96'(0));
      chk($sformatf("%s_d%0d_out_data", tag, dep[i]), od[i], '0);
    end
  endtask

  function automatic logic [95:0] rnd96();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_chk("rst");
    rst_n = 1'b1;

    // Fill, then reset mid-stream.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 96'h11; cyc();
    in_data = 96'h22; cyc();
    in_valid = 1'b0; cyc();
    rst_n = 1'b0;
    #2;
    rst_chk("midrst");
    for (int i = 0; i < 3; i++) mq[i].delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Streaming with downstream always ready.
    out_ready = 1'b1;
    for (int v = 1; v <= 8; v++) begin
      in_valid = 1'b1; in_data = 96'(v); cyc();
    end
    in_valid = 1'b0;
    repeat (4) cyc();

    // Back-pressure until full, then release.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 96'hA; cyc();
    in_data = 96'hB; cyc();
    in_data = 96'hC; cyc();
    in_data = 96'hD; repeat (2) cyc();
    out_ready = 1'b1; repeat (2) cyc();
    in_valid = 1'b0;
    repeat (5) cyc();

    // Flush with a concurrent push of 0x55.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 96'h21; cyc();
    in_data = 96'h22; cyc();
    flush = 1'b1; in_data = 96'h55; cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cyc();

    // DEPTH=1 throughput with full-width payloads.
    hs_d1 = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = rnd96();
    repeat (20) begin
      cyc();
      if (last_acc_d1) in_data = rnd96();
    end
`ifdef RV_PIPEBUF_BYPASS_EN
    chk("d1_throughput", 96'(hs_d1), 96'(20));
`else
    chk("d1_throughput", 96'(hs_d1), 96'(10));
`endif
    in_valid = 1'b0;
    repeat (3) cyc();

    // Random traffic with occasional flushes.
    repeat (400) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_data   = rnd96();
      cyc();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
